bp_lite_io_arbiter: RTL and testbench
=====================================

Name: bp_lite_io_arbiter

Overview:
- Shares one BP-lite IO port (io_cmd/io_resp, bedrock mem msg) among num_req_p requesters, e.g. the AXI-lite client bridge, a debug loader and a host link.
- Round-robin grant with one outstanding transaction. The command is passed through combinationally. The response is routed back to the owner.
- Sits between the requester bridges and the BP IO/CFG client port.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- msg_width_p, 512, width of one bedrock mem msg (cmd and resp identical); set from bp_out_mem_msg_width_lp.
- timeout_cycles_p, 1024, watchdog limit in cycles (only used with the optional feature).

Ports:
- aclk_i  in  1  clock.
- areset_i  in  1  reset, asynchronous, active-high.
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command, slice i = requester i.
- req_cmd_v_i  in  num_req_p  command valid; must stay stable until yumi.
- req_cmd_yumi_o  out  num_req_p  one-hot accept.
- req_resp_o  out  msg_width_p  response, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- io_cmd_o  out  msg_width_p  granted command.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  downstream accept.
- io_resp_i  in  msg_width_p  downstream response.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  response ready.
- grant_o  out  clog2(num_req_p)  current/last owner index (debug).
- busy_o  out  1  transaction outstanding.
- err_unexp_resp_o  out  1  sticky: a response arrived while idle.
- err_timeout_o  out  1  sticky: watchdog fired (0 when feature is off).

Behaviour:
- Reset state (async, areset_i=1):
  - state_r=e_idle, last_r=num_req_p-1, grant_r=0, sticky errors 0, counter 0.
  - All v/yumi/ready outputs 0; data outputs 0.
- e_idle:
  - Winner = first set bit of req_cmd_v_i searching from last_r+1 with wrap-around.
  - io_cmd_o = req_cmd_i[winner]; io_cmd_v_o = |req_cmd_v_i.
  - req_cmd_yumi_o[winner] = io_cmd_yumi_i; no other yumi bit is set.
  - When io_cmd_yumi_i & io_cmd_v_o: grant_r<=winner, last_r<=winner, go to e_resp. Zero added latency.
  - io_resp_ready_o=1 (drain). If io_resp_v_i: drop the response and set err_unexp_resp_o.
- e_resp:
  - io_cmd_v_o=0 and all yumi bits 0; new requests wait.
  - req_resp_o=io_resp_i; req_resp_v_o[grant_r]=io_resp_v_i; io_resp_ready_o=req_resp_ready_i[grant_r].
  - When io_resp_v_i & io_resp_ready_o: go to e_idle. The next grant may occur the cycle after.
- Same-cycle response and new request: the response completes first. A new command is only offered from e_idle.
- io_cmd_yumi_i while io_cmd_v_o=0: ignored (protocol violation, covered by a simulation assertion).
- busy_o = (state_r != e_idle). grant_o = grant_r.
- Sticky errors clear only on reset.
- Reset mid-transaction: return to e_idle. The in-flight response is later drained and flagged as unexpected.
- Simulation-only assertions:
  - num_req_p in 2..8.
  - req_cmd_yumi_o is one-hot0.

Optional Feature:
- Macro: BP_LITE_IO_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to e_resp and increments every cycle in e_resp.
  - Reaching timeout_cycles_p-1 with no handshake moves to e_timeout.
  - e_timeout: req_resp_v_o[grant_r]=1 with req_resp_o='0; io_resp_ready_o=1 (drops stale responses).
  - Leave e_timeout to e_idle on req_resp_ready_i[grant_r]; set err_timeout_o.
  - A response that arrives later in e_idle sets err_unexp_resp_o.
- Without the macro: no counter or e_timeout state; err_timeout_o is tied to 0; e_resp waits forever.

Decomposition:
- Package bp_lite_io_arb_pkg:
  - state enum bp_lite_io_arb_state_e {e_idle, e_resp, e_timeout}, 2 bits.
  - localparam for max requesters (8).
- One sub-module, bp_lite_rr_pick: combinational round-robin picker.
  - Inputs: v vector, last index. Outputs: winner index, any-valid.
  - Pointer register stays in the parent.

Test Plan:
- Single requester: req 0 valid, uc_rd addr 0x10, yumi on cycle 1 → yumi_o=01 same cycle, busy_o=1. Resp data 0xDEAD with ready → req_resp_v_o=01, back to idle next cycle.
- Fairness: all of 3 requesters continuously valid, immediate yumi/resp → grant sequence 0,1,2,0,1,2; no requester is granted twice before the others.
- Backpressure: owner 1 holds req_resp_ready_i=0 for 5 cycles with io_resp_v_i=1 → io_resp_ready_o=0 for those 5 cycles, state stays e_resp, req 0 gets no yumi.
- Unexpected response: io_resp_v_i=1 in idle → dropped, err_unexp_resp_o=1 and stays set until areset_i.
- Async reset: assert areset_i in e_resp off the clock edge → outputs 0 immediately, busy_o=0, last_r=num_req_p-1 so the next grant goes to req 0.
- TIMEOUT_EN with timeout_cycles_p=16: no response → on cycle 16 after the grant req_resp_v_o[owner]=1 with data 0 and err_timeout_o=1. A late response is then dropped and sets err_unexp_resp_o.

Source files
------------

// File: rtl/bp_lite_io_arbiter_pkg.sv
// bp_lite_io_arb_pkg: shared state type and limits for bp_lite_io_arbiter
package bp_lite_io_arb_pkg;
  localparam int max_req_lp = 8;
  typedef enum logic [1:0] {e_idle, e_resp, e_timeout} bp_lite_io_arb_state_e;
endpackage

// File: rtl/bp_lite_io_arbiter_if.sv
// bp_lite_io_arbiter_if: requester-side and IO-side signal bundle of bp_lite_io_arbiter
interface bp_lite_io_arbiter_if #(
  parameter int num_req_p = 2,
  parameter int msg_width_p = 512
);
  logic [num_req_p*msg_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0] req_cmd_v_i, req_cmd_yumi_o, req_resp_v_o, req_resp_ready_i;
  logic [msg_width_p-1:0] req_resp_o, io_cmd_o, io_resp_i;
  logic io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;
  logic busy_o, err_unexp_resp_o, err_timeout_o;
  logic [$clog2(num_req_p)-1:0] grant_o;
  modport slave (
    input req_cmd_i, req_cmd_v_i, req_resp_ready_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i,
    output req_cmd_yumi_o, req_resp_o, req_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o,
    output grant_o, busy_o, err_unexp_resp_o, err_timeout_o
  );
  modport master (
    output req_cmd_i, req_cmd_v_i, req_resp_ready_i, io_cmd_yumi_i, io_resp_i, io_resp_v_i,
    input req_cmd_yumi_o, req_resp_o, req_resp_v_o, io_cmd_o, io_cmd_v_o, io_resp_ready_o,
    input grant_o, busy_o, err_unexp_resp_o, err_timeout_o
  );
endinterface

// File: rtl/bp_lite_io_arbiter_rr_pick.sv
// bp_lite_rr_pick: combinational round-robin picker, first valid after last with wrap-around
module bp_lite_rr_pick #(
  parameter int num_req_p = 2,
  localparam int iw_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] v,
  input  logic [iw_lp-1:0] last,
  output logic [iw_lp-1:0] winner,
  output logic any
);
  logic [iw_lp-1:0] idx;
  assign any = |v;
  // walk the ring from farthest to nearest so the nearest valid after last wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = num_req_p; k >= 1; k--) begin
      idx = iw_lp'((int'(last) + k) % num_req_p);
      if (v[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/bp_lite_io_arbiter.sv
// bp_lite_io_arbiter: round-robin sharing of one BP-lite IO port, one outstanding transaction; watchdog under BP_LITE_IO_ARB_TIMEOUT_EN
module bp_lite_io_arbiter
  import bp_lite_io_arb_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int msg_width_p = 512,
  parameter int timeout_cycles_p = 1024,
  localparam int iw_lp = $clog2(num_req_p)
) (
  input logic aclk_i,
  input logic areset_i,
  bp_lite_io_arbiter_if.slave bus
);
  bp_lite_io_arb_state_e state_r;
  logic [iw_lp-1:0] last_r, grant_r, winner;
  logic [num_req_p-1:0] grant_oh;
  logic any, live, idle, resp, tmo, cmd_fire, resp_fire, err_unexp_r;
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
  localparam int cw_lp = $clog2(timeout_cycles_p);
  logic [cw_lp-1:0] cnt_r;
  logic err_to_r;
`endif
  if (num_req_p < 2 || num_req_p > max_req_lp || timeout_cycles_p < 2) begin : g_bad_param
    $error("bp_lite_io_arbiter: num_req_p must be 2..8 and timeout_cycles_p at least 2");
  end
  bp_lite_rr_pick #(.num_req_p(num_req_p)) pick (
    .v(bus.req_cmd_v_i), .last(last_r), .winner(winner), .any(any)
  );
  assign live = !areset_i;
  assign idle = state_r == e_idle;
  assign resp = state_r == e_resp;
  assign tmo = state_r == e_timeout;
  assign grant_oh = num_req_p'(1) << grant_r;
  assign cmd_fire = idle & any & bus.io_cmd_yumi_i;
  assign resp_fire = resp & bus.io_resp_v_i & bus.req_resp_ready_i[grant_r];
  // command pass-through from idle, response routing to the owner; everything quiet while in reset
  always_comb begin
    bus.io_cmd_o = live & idle ? bus.req_cmd_i[int'(winner)*msg_width_p +: msg_width_p] : '0;
    bus.io_cmd_v_o = live & idle & any;
    bus.req_cmd_yumi_o = live & cmd_fire ? num_req_p'(1) << winner : '0;
    bus.req_resp_o = live & resp ? bus.io_resp_i : '0;
    bus.req_resp_v_o = !live ? '0 : resp ? (bus.io_resp_v_i ? grant_oh : '0) : tmo ? grant_oh : '0;
    bus.io_resp_ready_o = live & (resp ? bus.req_resp_ready_i[grant_r] : 1'b1);
    bus.grant_o = grant_r;
    bus.busy_o = !idle;
    bus.err_unexp_resp_o = err_unexp_r;
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
    bus.err_timeout_o = err_to_r;
`else
    bus.err_timeout_o = 1'b0;
`endif
  end
  // transaction FSM, round-robin pointer, sticky errors and optional watchdog
  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) begin
      state_r <= e_idle;
      last_r <= iw_lp'(num_req_p - 1);
      grant_r <= '0;
      err_unexp_r <= 1'b0;
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
      cnt_r <= '0;
      err_to_r <= 1'b0;
`endif
    end else begin
      if (idle && bus.io_resp_v_i) err_unexp_r <= 1'b1;
      if (cmd_fire) begin
        state_r <= e_resp;
        grant_r <= winner;
        last_r <= winner;
      end
      if (resp_fire) state_r <= e_idle;
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
      cnt_r <= resp ? cnt_r + cw_lp'(1) : '0;
      if (resp && !resp_fire && cnt_r == cw_lp'(timeout_cycles_p - 1)) begin
        state_r <= e_timeout;
        err_to_r <= 1'b1;
      end
      if (tmo && bus.req_resp_ready_i[grant_r]) state_r <= e_idle;
`endif
    end
  assert property (@(posedge aclk_i) disable iff (areset_i) $onehot0(bus.req_cmd_yumi_o));
  assert property (@(posedge aclk_i) disable iff (areset_i) !(bus.io_cmd_yumi_i && !bus.io_cmd_v_o));
endmodule

// File: tb/tb_bp_lite_io_arbiter.sv
// tb_bp_lite_io_arbiter: directed checks of bp_lite_io_arbiter (3 requesters, 32-bit messages)
module tb_bp_lite_io_arbiter;
  localparam int n_lp = 3;
  localparam int w_lp = 32;
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
  localparam int to_lp = 16;
`else
  localparam int to_lp = 1024;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  bp_lite_io_arbiter_if #(.num_req_p(n_lp), .msg_width_p(w_lp)) bus ();
  bp_lite_io_arbiter #(.num_req_p(n_lp), .msg_width_p(w_lp), .timeout_cycles_p(to_lp)) dut (
    .aclk_i(clk), .areset_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.req_cmd_i = '0;
    bus.req_cmd_v_i = '0;
    bus.req_resp_ready_i = '0;
    bus.io_cmd_yumi_i = 1'b0;
    bus.io_resp_i = '0;
    bus.io_resp_v_i = 1'b0;
    #2;
    bus.req_cmd_v_i = 3'b111;
    bus.req_cmd_i[w_lp +: w_lp] = 32'h1234;
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_grant", bus.grant_o, 0);
    check("rst_cmd_v", bus.io_cmd_v_o, 0);
    check("rst_cmd", bus.io_cmd_o, 0);
    check("rst_resp_rdy", bus.io_resp_ready_o, 0);
    check("rst_err_unexp", bus.err_unexp_resp_o, 0);
    check("rst_err_to", bus.err_timeout_o, 0);
    bus.req_cmd_v_i = '0;
    @(negedge clk) rst = 1'b0;
    step();
    bus.req_cmd_i[0 +: w_lp] = 32'h0100_0010;
    bus.req_cmd_v_i = 3'b001;
    bus.io_cmd_yumi_i = 1'b1;
    #1;
    check("single_cmd_v", bus.io_cmd_v_o, 1);
    check("single_cmd", bus.io_cmd_o, 32'h0100_0010);
    check("single_yumi", bus.req_cmd_yumi_o, 3'b001);
    check("single_idle", bus.busy_o, 0);
    step();
    bus.req_cmd_v_i = '0;
    bus.io_cmd_yumi_i = 1'b0;
    bus.io_resp_i = 32'hDEAD;
    bus.io_resp_v_i = 1'b1;
    bus.req_resp_ready_i = 3'b001;
    #1;
    check("single_busy", bus.busy_o, 1);
    check("single_grant", bus.grant_o, 0);
    check("single_cmd_v_resp", bus.io_cmd_v_o, 0);
    check("single_resp_v", bus.req_resp_v_o, 3'b001);
    check("single_resp", bus.req_resp_o, 32'hDEAD);
    check("single_resp_rdy", bus.io_resp_ready_o, 1);
    step();
    bus.io_resp_v_i = 1'b0;
    #1;
    check("single_back_idle", bus.busy_o, 0);
    check("single_no_err", bus.err_unexp_resp_o, 0);
    for (int k = 0; k < n_lp; k++) bus.req_cmd_i[k*w_lp +: w_lp] = 32'hA0 + k;
    bus.req_cmd_v_i = 3'b111;
    bus.req_resp_ready_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      bus.io_cmd_yumi_i = 1'b1;
      #1;
      check("fair_cmd", bus.io_cmd_o, 32'hA0 + (k + 1) % 3);
      check("fair_yumi", bus.req_cmd_yumi_o, 3'b001 << ((k + 1) % 3));
      step();
      bus.io_cmd_yumi_i = 1'b0;
      bus.io_resp_i = 32'(k);
      bus.io_resp_v_i = 1'b1;
      #1;
      check("fair_grant", bus.grant_o, (k + 1) % 3);
      check("fair_resp_v", bus.req_resp_v_o, 3'b001 << ((k + 1) % 3));
      step();
      bus.io_resp_v_i = 1'b0;
    end
    bus.req_cmd_v_i = 3'b011;
    bus.io_cmd_yumi_i = 1'b1;
    #1;
    check("bp_yumi", bus.req_cmd_yumi_o, 3'b010);
    step();
    bus.io_cmd_yumi_i = 1'b0;
    bus.io_resp_i = 32'hBEEF;
    bus.io_resp_v_i = 1'b1;
    bus.req_resp_ready_i = 3'b001;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_resp_rdy", bus.io_resp_ready_o, 0);
      check("bp_busy", bus.busy_o, 1);
      check("bp_cmd_v", bus.io_cmd_v_o, 0);
      check("bp_resp_v", bus.req_resp_v_o, 3'b010);
      step();
    end
    bus.req_resp_ready_i = 3'b011;
    #1;
    check("bp_release_rdy", bus.io_resp_ready_o, 1);
    step();
    bus.io_resp_v_i = 1'b0;
    #1;
    check("bp_idle", bus.busy_o, 0);
    check("bp_next_cmd_v", bus.io_cmd_v_o, 1);
    check("bp_next_cmd", bus.io_cmd_o, 32'hA0);
    bus.req_cmd_v_i = '0;
    bus.io_resp_v_i = 1'b1;
    #1;
    check("unexp_drain_rdy", bus.io_resp_ready_o, 1);
    check("unexp_no_route", bus.req_resp_v_o, 0);
    step();
    bus.io_resp_v_i = 1'b0;
    #1;
    check("unexp_err_set", bus.err_unexp_resp_o, 1);
    repeat (3) step();
    check("unexp_err_sticky", bus.err_unexp_resp_o, 1);
    bus.req_cmd_v_i = 3'b111;
    bus.io_cmd_yumi_i = 1'b1;
    step();
    bus.io_cmd_yumi_i = 1'b0;
    #1;
    check("arst_pre_busy", bus.busy_o, 1);
    check("arst_pre_grant", bus.grant_o, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy_o, 0);
    check("arst_grant", bus.grant_o, 0);
    check("arst_err_clr", bus.err_unexp_resp_o, 0);
    check("arst_resp_rdy", bus.io_resp_ready_o, 0);
    check("arst_cmd_v", bus.io_cmd_v_o, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("arst_next_cmd", bus.io_cmd_o, 32'hA0);
    bus.io_cmd_yumi_i = 1'b1;
    #1;
    check("arst_next_yumi", bus.req_cmd_yumi_o, 3'b001);
    step();
    bus.io_cmd_yumi_i = 1'b0;
    bus.req_cmd_v_i = '0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bus.io_resp_v_i = 1'b1;
    step();
    bus.io_resp_v_i = 1'b0;
    #1;
    check("arst_inflight_unexp", bus.err_unexp_resp_o, 1);
`ifdef BP_LITE_IO_ARB_TIMEOUT_EN
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    bus.req_resp_ready_i = '0;
    bus.io_resp_i = 32'hDEAD;
    bus.req_cmd_v_i = 3'b001;
    bus.io_cmd_yumi_i = 1'b1;
    step();
    bus.io_cmd_yumi_i = 1'b0;
    bus.req_cmd_v_i = '0;
    repeat (15) step();
    check("to_wait_busy", bus.busy_o, 1);
    check("to_wait_resp_v", bus.req_resp_v_o, 0);
    check("to_wait_err", bus.err_timeout_o, 0);
    step();
    check("to_resp_v", bus.req_resp_v_o, 3'b001);
    check("to_resp_zero", bus.req_resp_o, 0);
    check("to_err", bus.err_timeout_o, 1);
    check("to_drain_rdy", bus.io_resp_ready_o, 1);
    bus.req_resp_ready_i = 3'b001;
    step();
    check("to_back_idle", bus.busy_o, 0);
    bus.io_resp_v_i = 1'b1;
    step();
    bus.io_resp_v_i = 1'b0;
    #1;
    check("to_late_unexp", bus.err_unexp_resp_o, 1);
    check("to_err_sticky", bus.err_timeout_o, 1);
`else
    check("no_to_err", bus.err_timeout_o, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
